minivan_alu_pipe: RTL and testbench
===================================

Name: minivan_alu_pipe

Overview:
- Parametrised successor to the minivan combinational subtractor.
- Two-stage pipelined add/subtract unit: wrap and signed-saturating modes, unsigned absolute difference, and a wide running accumulator of signed differences.
- Valid/ready handshake on input and output; sits between the TT pin-mux/sequencer and uo_out so operands can be streamed at one per cycle.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2)
- ACC_WIDTH, 16, accumulator width in bits (must be >= WIDTH+1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  global enable; when 0 the pipeline does not advance (treated as a stall)
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  3  opcode (see Behaviour)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_res  output  WIDTH  result
- out_flags  output  5  {sat, ovf, carry, neg, zero}
- acc_q  output  ACC_WIDTH  current accumulator value

Behaviour:
- Opcodes:
  - 0 SUB: a-b wrap
  - 1 ADD: a+b wrap
  - 2 SUBS: signed a-b, saturating
  - 3 ADDS: signed a+b, saturating
  - 4 ABSD: unsigned |a-b|
  - 5 ACC: acc += sext(a)-sext(b), wrap at ACC_WIDTH; result = acc_next[WIDTH-1:0]
  - 6 ACLR: acc <= 0, result 0
  - 7 reserved: result 0, acc unchanged
- Flags:
  - zero: res==0
  - neg: res[WIDTH-1]
  - carry: carry-out for ADD/ADDS; borrow (a<b unsigned) for SUB/SUBS/ABSD; 0 otherwise
  - ovf: signed overflow of the exact result before saturation (for ACC: of the ACC_WIDTH sum); 0 for ABSD/ACLR/7
  - sat: saturation applied (SUBS/ADDS only)
- Saturation clamps to 0x7F..F on positive overflow and 0x80..0 on negative overflow.
- Pipeline stages:
  - S1 registers {a, b, op, valid}.
  - S2 computes from S1 and registers {res, flags, valid}.
  - The accumulator updates on the S1->S2 transfer, so updates occur in issue order.
- Flow control:
  - advance = ena & (!out_valid | out_ready)
  - in_ready = advance (combinational from out_ready/ena/out_valid)
  - On advance: S1 <= input beat (valid = in_valid); S2 <= computed S1 (valid = S1 valid).
  - Stall holds all stage registers and acc unchanged.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1 if unstalled. Throughput is 1 beat/cycle.
- Backpressure: out_res/out_flags are stable while out_valid & !out_ready. No beat is dropped or duplicated.
- S1 holding a bubble (valid=0): no acc update; S2 valid clears on advance.
- ACC wraps silently at 2^ACC_WIDTH with ovf=1 on signed overflow.
- Reset (asynchronous, any time, including mid-stream):
  - all valids 0, out_res 0, out_flags 0, acc_q 0, S1 data 0
  - in_ready = ena after reset
  - in-flight beats discarded
- Simultaneous out accept and new input in the same cycle is legal and keeps full rate.

Decomposition:
- Package minivan_alu_pkg:
  - op enum (OP_SUB..OP_RSVD, 3 bits)
  - flag bit index constants (FLG_ZERO=0 .. FLG_SAT=4)
  - flags struct typedef
- One combinational sub-module minivan_alu_core: S1 operands, op and acc in -> res, flags, acc_next. Instantiated between S1 and S2.
- Handshake, pipeline registers and acc register live in the top.

Test Plan:
- SUB a=0x05 b=0x07 -> res 0xFE, flags carry=1 neg=1 zero=0; ADD 0xFF+0x01 -> res 0x00 carry=1 zero=1; out_valid exactly 2 cycles after accept.
- SUBS 0x80-0x01 -> res 0x80, ovf=1 sat=1; ADDS 0x7F+0x01 -> res 0x7F, ovf=1 sat=1; ADDS 0x10+0x20 -> 0x30, sat=0.
- ABSD a=0x03 b=0x10 -> res 0x0D, carry=1; a=0x10 b=0x03 -> 0x0D, carry=0.
- ACLR, then ACC (10,3) -> acc_q 0x0007, res 0x07; then ACC (5,20) -> acc_q 0xFFF8, res 0xF8, neg=1; then ACLR -> acc_q 0x0000, zero=1.
- Stream of 4 back-to-back beats with out_ready low for 3 cycles mid-stream -> in_ready low while stalled, outputs held stable, all 4 results in order, acc updated exactly once per ACC beat; ena=0 behaves identically to the stall.
- Assert rst_n low asynchronously with 2 beats in flight and acc=0x0123 -> out_valid, out_flags, out_res, acc_q immediately 0; after release the first new beat produces a correct result with no stale output.

Source files
------------

// File: rtl/minivan_alu_pkg.sv
// Shared opcode encoding, flag bit positions and flag bundle for the minivan ALU pipe.
package minivan_alu_pkg;

  typedef enum logic [2:0] {
    OP_SUB  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUBS = 3'd2,
    OP_ADDS = 3'd3,
    OP_ABSD = 3'd4,
    OP_ACC  = 3'd5,
    OP_ACLR = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_NEG   = 1;
  localparam int FLG_CARRY = 2;
  localparam int FLG_OVF   = 3;
  localparam int FLG_SAT   = 4;

  typedef struct packed {
    logic sat;
    logic ovf;
    logic carry;
    logic neg;
    logic zero;
  } flags_t;

endpackage

// File: rtl/minivan_alu_core.sv
// Combinational add/subtract datapath: wrap, saturating, absolute difference and
// accumulator update, evaluated on the operands held in the first pipeline stage.
module minivan_alu_core
  import minivan_alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [WIDTH-1:0]     res,
  output logic [4:0]           flags,
  output logic [ACC_WIDTH-1:0] acc_next
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  op_t                  op_e;
  flags_t               flg;
  logic [WIDTH:0]       sum_u;
  logic [WIDTH:0]       diff_u;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic                 borrow;
  logic                 add_ovf;
  logic                 sub_ovf;
  logic [ACC_WIDTH-1:0] delta;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_ovf;
  logic [WIDTH-1:0]     res_c;

  assign op_e    = op_t'(op);
  assign sum_u   = {1'b0, a} + {1'b0, b};
  assign diff_u  = {1'b0, a} - {1'b0, b};
  assign sum_s   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign diff_s  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign borrow  = diff_u[WIDTH];
  assign add_ovf = sum_s[WIDTH] ^ sum_s[WIDTH-1];
  assign sub_ovf = diff_s[WIDTH] ^ diff_s[WIDTH-1];

  // The exact WIDTH+1 bit signed difference is sign-extended up to the accumulator width.
  assign delta[WIDTH:0] = diff_s;
  for (genvar gi = WIDTH + 1; gi < ACC_WIDTH; gi++) begin : g_sext
    assign delta[gi] = diff_s[WIDTH];
  end

  assign acc_sum = acc + delta;
  assign acc_ovf = (acc[ACC_WIDTH-1] == delta[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

  always_comb begin
    res_c     = '0;
    flg       = '0;
    acc_next  = acc;
    case (op_e)
      OP_SUB: begin
        res_c     = diff_u[WIDTH-1:0];
        flg.carry = borrow;
        flg.ovf   = sub_ovf;
      end
      OP_ADD: begin
        res_c     = sum_u[WIDTH-1:0];
        flg.carry = sum_u[WIDTH];
        flg.ovf   = add_ovf;
      end
      OP_SUBS: begin
        res_c     = sub_ovf ? (diff_s[WIDTH] ? SMIN : SMAX) : diff_s[WIDTH-1:0];
        flg.carry = borrow;
        flg.ovf   = sub_ovf;
        flg.sat   = sub_ovf;
      end
      OP_ADDS: begin
        res_c     = add_ovf ? (sum_s[WIDTH] ? SMIN : SMAX) : sum_s[WIDTH-1:0];
        flg.carry = sum_u[WIDTH];
        flg.ovf   = add_ovf;
        flg.sat   = add_ovf;
      end
      OP_ABSD: begin
        res_c     = borrow ? (b - a) : (a - b);
        flg.carry = borrow;
      end
      OP_ACC: begin
        acc_next  = acc_sum;
        res_c     = acc_sum[WIDTH-1:0];
        flg.ovf   = acc_ovf;
      end
      OP_ACLR: acc_next = '0;
      default: ;
    endcase
    flg.zero = (res_c == '0);
    flg.neg  = res_c[WIDTH-1];
  end

  assign res   = res_c;
  assign flags = flg;

endmodule

// File: rtl/minivan_alu_pipe.sv
// Two-stage valid/ready add/subtract pipe with a running accumulator; the
// accumulator commits on the stage-1 to stage-2 transfer so updates follow issue order.
module minivan_alu_pipe
  import minivan_alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_res,
  output logic [4:0]           out_flags,
  output logic [ACC_WIDTH-1:0] acc_q
);

  logic [WIDTH-1:0]     s1_a_reg;
  logic [WIDTH-1:0]     s1_b_reg;
  logic [2:0]           s1_op_reg;
  logic                 s1_valid_reg;
  logic [WIDTH-1:0]     out_res_reg;
  logic [4:0]           out_flags_reg;
  logic                 out_valid_reg;
  logic [ACC_WIDTH-1:0] acc_reg;

  logic [WIDTH-1:0]     res_next;
  logic [4:0]           flags_next;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 advance;

  // Both stages move together; a full output stage blocks everything behind it.
  assign advance  = ena & (~out_valid_reg | out_ready);
  assign in_ready = advance;

  minivan_alu_core #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_core (
    .a        (s1_a_reg),
    .b        (s1_b_reg),
    .op       (s1_op_reg),
    .acc      (acc_reg),
    .res      (res_next),
    .flags    (flags_next),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_reg      <= '0;
      s1_b_reg      <= '0;
      s1_op_reg     <= '0;
      s1_valid_reg  <= 1'b0;
      out_res_reg   <= '0;
      out_flags_reg <= '0;
      out_valid_reg <= 1'b0;
      acc_reg       <= '0;
    end else if (advance) begin
      s1_a_reg      <= in_a;
      s1_b_reg      <= in_b;
      s1_op_reg     <= in_op;
      s1_valid_reg  <= in_valid;
      out_valid_reg <= s1_valid_reg;
      // Bubbles leave the result registers and accumulator untouched.
      if (s1_valid_reg) begin
        out_res_reg   <= res_next;
        out_flags_reg <= flags_next;
        acc_reg       <= acc_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_flags = out_flags_reg;
  assign acc_q     = acc_reg;

endmodule

// File: tb/tb_minivan_alu_pipe.sv
// Scoreboard bench for minivan_alu_pipe: expected beats are queued at acceptance
// and compared, together with the accumulator, when the pipe hands a result out.
module tb_minivan_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic [4:0]  out_flags;
  logic [15:0] acc_q;

  typedef struct {
    logic [7:0]  res;
    logic [4:0]  flags;
    logic [15:0] acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [15:0] model_acc;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          hold_prev;
  logic [7:0]  prev_res;
  logic [4:0]  prev_flags;
  logic [7:0]  last_res;
  logic [4:0]  last_flags;
  bit          rnd_done;

  minivan_alu_pipe #(.WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags),
    .acc_q     (acc_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model built on integer arithmetic.
  task automatic model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                       output exp_t e);
    int ua, ub, sa, sbv, sx, rv, accv;
    bit carry, ovf, sat;
    ua = a; ub = b; sa = $signed(a); sbv = $signed(b);
    carry = 0; ovf = 0; sat = 0; rv = 0;
    case (op)
      3'd0: begin rv = ua - ub; carry = ua < ub; sx = sa - sbv; ovf = sx > 127 || sx < -128; end
      3'd1: begin rv = ua + ub; carry = (ua + ub) > 255; sx = sa + sbv; ovf = sx > 127 || sx < -128; end
      3'd2: begin
        carry = ua < ub; sx = sa - sbv; ovf = sx > 127 || sx < -128; sat = ovf;
        rv = (sx > 127) ? 127 : ((sx < -128) ? -128 : sx);
      end
      3'd3: begin
        carry = (ua + ub) > 255; sx = sa + sbv; ovf = sx > 127 || sx < -128; sat = ovf;
        rv = (sx > 127) ? 127 : ((sx < -128) ? -128 : sx);
      end
      3'd4: begin rv = (ua >= ub) ? ua - ub : ub - ua; carry = ua < ub; end
      3'd5: begin
        accv = int'($signed(model_acc)) + sa - sbv;
        ovf = accv > 32767 || accv < -32768;
        model_acc = accv[15:0];
        rv = accv;
      end
      3'd6: begin model_acc = 16'h0; rv = 0; end
      default: rv = 0;
    endcase
    e.res   = rv[7:0];
    e.flags = {sat, ovf, carry, e.res[7], e.res == 8'h00};
    e.acc   = model_acc;
  endtask

  // Presents one beat and returns just after the edge that accepted it; in_valid stays high.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    exp_t e;
    bit   ok;
    int   n;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    else begin
      model(a, b, op, e);
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    #1;
  endtask

  // Single beat into an empty pipe, with latency checks on out_valid.
  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    send(a, b, op);
    in_valid = 1'b0;
    check("lat_after_accept_edge", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_after_next_edge", out_valid, 1'b1);
    drain();
  endtask

  task automatic stall_for(input bit use_ena);
    repeat (2) @(posedge clk);
    #2;
    if (use_ena) ena = 1'b0;
    else out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check(use_ena ? "ena_stall_in_ready" : "stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #2;
    ena = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic stream4(input bit use_ena);
    fork
      begin
        send(8'd1, 8'd2, 3'd5);
        send(8'd3, 8'd4, 3'd1);
        send(8'h40, 8'h10, 3'd5);
        send(8'h90, 8'h70, 3'd2);
        in_valid = 1'b0;
      end
      stall_for(use_ena);
    join
    drain();
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_res", out_res, prev_res);
        check("hold_flags", out_flags, prev_flags);
      end
      if (out_valid && out_ready && ena) begin
        check("sb_nonempty_on_out", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          $display("txn res=0x%02h flags=%05b acc=0x%04h (exp res=0x%02h flags=%05b acc=0x%04h)",
                   out_res, out_flags, acc_q, mon_e.res, mon_e.flags, mon_e.acc);
          check("res", out_res, mon_e.res);
          check("flags", out_flags, mon_e.flags);
          check("acc", acc_q, mon_e.acc);
          last_res   = out_res;
          last_flags = out_flags;
        end
      end
      hold_prev  = out_valid && !(out_ready && ena);
      prev_res   = out_res;
      prev_flags = out_flags;
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; out_ready = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    model_acc = 16'h0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_res", out_res, 8'h00);
    check("rst_out_flags", out_flags, 5'h00);
    check("rst_acc", acc_q, 16'h0000);
    check("rst_in_ready", in_ready, 1'b1);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run1(8'h05, 8'h07, 3'd0);
    check("sub_res", last_res, 8'hFE);
    check("sub_flags", last_flags, 5'b00110);
    run1(8'hFF, 8'h01, 3'd1);
    check("add_res", last_res, 8'h00);
    check("add_flags", last_flags, 5'b00101);
    run1(8'h80, 8'h01, 3'd2);
    check("subs_res", last_res, 8'h80);
    check("subs_flags", last_flags, 5'b11010);
    run1(8'h7F, 8'h01, 3'd3);
    check("adds_sat_res", last_res, 8'h7F);
    check("adds_sat_flags", last_flags, 5'b11000);
    run1(8'h10, 8'h20, 3'd3);
    check("adds_res", last_res, 8'h30);
    check("adds_flags", last_flags, 5'b00000);
    run1(8'h03, 8'h10, 3'd4);
    check("absd_lo_res", last_res, 8'h0D);
    check("absd_lo_flags", last_flags, 5'b00100);
    run1(8'h10, 8'h03, 3'd4);
    check("absd_hi_res", last_res, 8'h0D);
    check("absd_hi_flags", last_flags, 5'b00000);

    run1(8'h00, 8'h00, 3'd6);
    run1(8'd10, 8'd3, 3'd5);
    check("acc1_q", acc_q, 16'h0007);
    check("acc1_res", last_res, 8'h07);
    run1(8'd5, 8'd20, 3'd5);
    check("acc2_q", acc_q, 16'hFFF8);
    check("acc2_res", last_res, 8'hF8);
    check("acc2_flags", last_flags, 5'b00010);
    run1(8'h00, 8'h00, 3'd6);
    check("aclr_q", acc_q, 16'h0000);
    check("aclr_flags", last_flags, 5'b00001);
    run1(8'h11, 8'h22, 3'd7);

    stream4(1'b0);
    stream4(1'b1);

    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
          ena = ($urandom_range(0, 7) != 0);
        end
        out_ready = 1'b1;
        ena = 1'b1;
      end
    join
    drain();

    run1(8'h00, 8'h00, 3'd6);
    run1(8'h7F, 8'h80, 3'd5);
    run1(8'h24, 8'h00, 3'd5);
    check("pre_rst_acc", acc_q, 16'h0123);
    out_ready = 1'b0;
    send(8'h01, 8'h01, 3'd1);
    send(8'h09, 8'h02, 3'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("inflight_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_res", out_res, 8'h00);
    check("arst_out_flags", out_flags, 5'h00);
    check("arst_acc", acc_q, 16'h0000);
    sb.delete();
    model_acc = 16'h0;
    out_ready = 1'b1;
    check("arst_in_ready", in_ready, 1'b1);
    #10;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_no_stale", out_valid, 1'b0);
    run1(8'h20, 8'h05, 3'd0);
    check("post_rst_res", last_res, 8'h1B);
    check("post_rst_acc", acc_q, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
